// File: rtl/seq_arb_pkg.sv
// Shared definitions for the round-robin sequence-detector arbiter: FSM encoding,
// default pattern and a width helper.
package seq_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    DRAIN  = ST_DRAIN,
    REPORT = ST_REPORT
  } arb_state_e;

  localparam int              DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1010;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Moore serial pattern detector with a registered output. Overlapping matches are
// detected when SEQ_DET_OVERLAP_EN is defined; otherwise a match restarts the search.
module seq_match_core
  import seq_arb_pkg::*;
#(
  parameter int              PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  localparam int             FW      = clog2w(PAT_W + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic in,
  output logic out
);

  logic [PAT_W-1:0] sh_q, sh_d, sh_n;
  logic [FW-1:0]    fill_q, fill_d, fill_n;
  logic             out_q, out_d;
  logic             hit;

  // The state is the last PAT_W bits plus how many of them belong to the current
  // search; a match needs a full window of eligible bits equal to PATTERN.
  always_comb begin
    sh_n   = PAT_W'({sh_q, in});
    fill_n = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + FW'(1);
    hit    = (fill_n == FW'(PAT_W)) && (sh_n == PATTERN);

    sh_d   = sh_q;
    fill_d = fill_q;
    out_d  = out_q;
    if (clr) begin
      sh_d   = '0;
      fill_d = '0;
      out_d  = 1'b0;
    end else if (en) begin
      sh_d  = sh_n;
      out_d = hit;
`ifdef SEQ_DET_OVERLAP_EN
      fill_d = fill_n;
`else
      fill_d = hit ? '0 : fill_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_q   <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      fill_q <= fill_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter sharing one serial pattern detector across NREQ requesters,
// one fixed-length frame at a time. Overlap mode selected by SEQ_DET_OVERLAP_EN.
module seq_detect_arbiter
  import seq_arb_pkg::*;
#(
  parameter int               NREQ      = 4,
  parameter int               FRAME_LEN = 16,
  parameter int               PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN   = PAT_W'(DEF_PATTERN),
  localparam int              IDW       = clog2w(NREQ),
  localparam int              CNTW      = clog2w(FRAME_LEN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [IDW-1:0]  done_id,
  output logic [CNTW-1:0] match_count
);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CNTW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            aborted_q, aborted_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [CNTW-1:0] match_count_q, match_count_d;

  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic [CNTW-1:0] cnt_next;
  logic            det_clr;
  logic            det_en;
  logic            det_out;

  // Walk from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    winner = last_q;
    cand   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDW'((int'(last_q) + i) % NREQ);
      if (req[cand]) winner = cand;
    end
  end

  seq_match_core #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .en    (det_en),
    .in    (din[id_q]),
    .out   (det_out)
  );

  assign cnt_next = cnt_q + CNTW'(det_out);

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    last_d        = last_q;
    bit_cnt_d     = bit_cnt_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    done_d        = 1'b0;
    aborted_d     = aborted_q;
    done_id_d     = done_id_q;
    match_count_d = match_count_q;
    det_clr       = 1'b0;
    det_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Clearing here guarantees no match can straddle two frames.
        det_clr = 1'b1;
        if (|req) begin
          id_d      = winner;
          last_d    = winner;
          bit_cnt_d = '0;
          cnt_d     = '0;
          gnt_d     = NREQ'(1) << winner;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        cnt_d = cnt_next;
        if (!req[id_q]) begin
          gnt_d         = '0;
          done_d        = 1'b1;
          aborted_d     = 1'b1;
          done_id_d     = id_q;
          match_count_d = cnt_next;
          state_d       = REPORT;
        end else begin
          det_en    = 1'b1;
          bit_cnt_d = bit_cnt_q + CNTW'(1);
          if (bit_cnt_q == CNTW'(FRAME_LEN - 1)) begin
            gnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The last bit's match becomes visible only now, so count once more.
        cnt_d         = cnt_next;
        done_d        = 1'b1;
        aborted_d     = 1'b0;
        done_id_d     = id_q;
        match_count_d = cnt_next;
        state_d       = REPORT;
      end
      REPORT: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      id_q          <= '0;
      last_q        <= IDW'(NREQ - 1);
      bit_cnt_q     <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      done_id_q     <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      last_q        <= last_d;
      bit_cnt_q     <= bit_cnt_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      done_id_q     <= done_id_d;
      match_count_q <= match_count_d;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign done_id     = done_id_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Scoreboard bench for seq_detect_arbiter (NREQ=4, FRAME_LEN=8, PATTERN=1010);
// expectations follow SEQ_DET_OVERLAP_EN when it is defined.
module tb_seq_detect_arbiter;

  localparam int FL = 8;
  localparam int PW = 4;
  localparam logic [3:0] PAT = 4'b1010;
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic [3:0] gnt;
  logic       busy, done, aborted;
  logic [1:0] done_id;
  logic [3:0] match_count;

  int checks = 0;
  int errors = 0;

  typedef struct { int id; int cnt; bit ab; } exp_t;
  exp_t sb[$];

  seq_detect_arbiter #(
    .NREQ(4), .FRAME_LEN(FL), .PAT_W(PW), .PATTERN(PAT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt), .busy(busy),
    .done(done), .aborted(aborted), .done_id(done_id), .match_count(match_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference count by direct window scan; seq[FL-1] is the first bit received.
  function automatic int ref_count(input logic [7:0] seq, input int n);
    int c, last;
    logic [3:0] p;
    logic m;
    c = 0; last = -100; p = PAT;
    for (int i = PW - 1; i < n; i++) begin
      m = 1'b1;
      for (int j = 0; j < PW; j++)
        if (seq[FL-1-(i-PW+1+j)] != p[PW-1-j]) m = 1'b0;
      if (m && (OVL || (i - last) >= PW)) begin c++; last = i; end
    end
    return c;
  endfunction

  // Runs one frame from IDLE; nbits < FL drops the request after nbits samples.
  task automatic do_frame(input logic [3:0] rq, input int exp_id,
                          input logic [7:0] seq, input int nbits);
    exp_t e, got;
    int lat;
    logic [3:0] exp_gnt;
    exp_gnt = 4'(1 << exp_id);
    req = rq; din = '0;
    e.id = exp_id; e.cnt = ref_count(seq, nbits); e.ab = (nbits < FL);
    sb.push_back(e);
    @(posedge clk); #1;
    checks++;
    if (gnt !== exp_gnt || busy !== 1'b1) begin
      errors++; $display("FAIL grant: gnt=%b busy=%b required gnt=%b busy=1", gnt, busy, exp_gnt);
    end
    for (int i = 0; i < nbits; i++) begin
      din[exp_id] = seq[FL-1-i];
      @(posedge clk); #1;
      if (i < FL - 1) begin
        checks++;
        if (gnt !== exp_gnt || done !== 1'b0) begin
          errors++; $display("FAIL stream_gnt bit %0d: gnt=%b done=%b required gnt=%b done=0", i, gnt, done, exp_gnt);
        end
      end
    end
    din = '0;
    if (nbits < FL) begin
      req[exp_id] = 1'b0;
      @(posedge clk); #1;
    end else begin
      checks++;
      if (gnt !== 4'b0 || done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL drain: gnt=%b done=%b busy=%b required 0000/0/1", gnt, done, busy);
      end
    end
    lat = 0;
    while (done !== 1'b1 && lat < 4) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_timeout: done=%b required 1 within 4 cycles", done);
    end else begin
      if (lat !== (got.ab ? 0 : 1)) begin
        errors++; $display("FAIL done_latency: %0d cycles required %0d", lat, got.ab ? 0 : 1);
      end
      checks++;
      if (int'(done_id) != got.id || int'(match_count) != got.cnt || aborted !== got.ab) begin
        errors++; $display("FAIL report: id=%0d cnt=%0d ab=%b required id=%0d cnt=%0d ab=%b",
                           done_id, match_count, aborted, got.id, got.cnt, got.ab);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || int'(done_id) != got.id || int'(match_count) != got.cnt) begin
      errors++; $display("FAIL after_report: done=%b busy=%b id=%0d cnt=%0d required 0/0/%0d/%0d",
                         done, busy, done_id, match_count, got.id, got.cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
        done_id !== 2'd0 || match_count !== 4'd0) begin
      errors++; $display("FAIL reset_state: gnt=%b busy=%b done=%b ab=%b id=%0d cnt=%0d required all 0",
                         gnt, busy, done, aborted, done_id, match_count);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      errors++; $display("FAIL idle_no_req: busy=%b gnt=%b required 0/0000", busy, gnt);
    end
  endtask

  task automatic test_single_frame();
    do_frame(4'b0001, 0, 8'b10101000, FL);
    req = '0;
  endtask

  task automatic test_round_robin();
    int ids[4];
    ids = '{1, 3, 1, 3};
    for (int f = 0; f < 4; f++) do_frame(4'b1010, ids[f], 8'($urandom), FL);
    req = '0;
  endtask

  task automatic test_final_bit();
    do_frame(4'b0001, 0, 8'b00001010, FL);
    req = '0;
  endtask

  task automatic test_back_to_back();
    do_frame(4'b0001, 0, 8'b10100101, FL);
    do_frame(4'b0001, 0, 8'b00000000, FL);
    req = '0;
  endtask

  task automatic test_abort();
    do_frame(4'b0001, 0, 8'b10100000, 3);
    req = '0;
  endtask

  task automatic test_reset_mid_stream();
    logic seen_done;
    req = 4'b0100; din = '0;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL pre_reset_grant: gnt=%b required 0100", gnt);
    end
    for (int i = 0; i < 3; i++) begin
      din[2] = i[0] ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; req = '0; din = '0;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || match_count !== 4'd0 || done_id !== 2'd0) begin
      errors++; $display("FAIL mid_reset: gnt=%b busy=%b done=%b cnt=%0d id=%0d required 0000/0/0/0/0",
                         gnt, busy, done, match_count, done_id);
    end
    seen_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL no_done_after_reset: done pulsed, required none");
    end
    do_frame(4'b1001, 0, 8'b11010100, FL);
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_final_bit();
    test_back_to_back();
    test_abort();
    test_reset_mid_stream();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
